// File: rtl/uart_rx_fifo.sv
// Receive-side FIFO between the UART receiver and the byte consumer.
// Stores {frame_err, parity_err, data} per character with a first-word fall-through read port.
module uart_rx_fifo #(
  parameter int DATA_BITS = 8,
  parameter int DEPTH     = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DATA_BITS-1:0]       rx_data,
  input  logic                       data_ready,
  input  logic                       parity_err,
  input  logic                       frame_err,
  output logic [DATA_BITS-1:0]       rd_data,
  output logic                       rd_parity_err,
  output logic                       rd_frame_err,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow,
  input  logic                       overflow_clr
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = DATA_BITS + 2;
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);

  typedef struct packed {
    logic                 frame_err;
    logic                 parity_err;
    logic [DATA_BITS-1:0] data;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          head;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic            push, pop, drop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign rd_valid = ~empty;
  assign level    = count;

  assign pop  = rd_valid & rd_ready;
  // A full FIFO still takes a byte when the head leaves in the same cycle.
  assign push = data_ready & (~full | pop);
  assign drop = data_ready & full & ~pop;

  assign head          = mem[rd_ptr];
  assign rd_data       = head.data;
  assign rd_parity_err = head.parity_err;
  assign rd_frame_err  = head.frame_err;

  // Storage is intentionally left out of reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{frame_err: frame_err, parity_err: parity_err, data: rx_data};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !pop)      count <= count + CNT_ONE;
      else if (pop && !push) count <= count - CNT_ONE;
      // A drop in the same cycle as a clear keeps the flag set.
      if (drop)              overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;
    end
  end

  logic unused_ok;
  assign unused_ok = &{1'b0, EW[0]};
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: queue-based reference model compared every cycle,
// plus directed scenarios pinned with literal expectations.
module tb_uart_rx_fifo;
  localparam int DATA_BITS = 8;
  localparam int DEPTH     = 16;
  localparam int LW        = $clog2(DEPTH) + 1;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic [DATA_BITS-1:0] rx_data = '0;
  logic                 data_ready = 1'b0;
  logic                 parity_err = 1'b0;
  logic                 frame_err = 1'b0;
  logic [DATA_BITS-1:0] rd_data;
  logic                 rd_parity_err, rd_frame_err, rd_valid;
  logic                 rd_ready = 1'b0;
  logic [LW-1:0]        level;
  logic                 full, empty, overflow;
  logic                 overflow_clr = 1'b0;

  uart_rx_fifo #(.DATA_BITS(DATA_BITS), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .data_ready(data_ready),
    .parity_err(parity_err), .frame_err(frame_err), .rd_data(rd_data),
    .rd_parity_err(rd_parity_err), .rd_frame_err(rd_frame_err), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .level(level), .full(full), .empty(empty),
    .overflow(overflow), .overflow_clr(overflow_clr)
  );

  always #5 clk = ~clk;

  logic [DATA_BITS+1:0] q[$];
  bit                   m_ovf;
  int                   ntests, nfail;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic compare();
    chk("level", 32'(level), 32'(q.size()));
    chk("full", 32'(full), 32'(q.size() == DEPTH));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("rd_valid", 32'(rd_valid), 32'(q.size() != 0));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    if (q.size() != 0) begin
      chk("rd_data", 32'(rd_data), 32'(q[0][DATA_BITS-1:0]));
      chk("rd_parity_err", 32'(rd_parity_err), 32'(q[0][DATA_BITS]));
      chk("rd_frame_err", 32'(rd_frame_err), 32'(q[0][DATA_BITS+1]));
    end
  endtask

  // Advance one clock: update the model from the inputs held across the edge, then compare.
  task automatic tick();
    int sz;
    bit p, dropped;
    @(posedge clk);
    sz = q.size();
    p = (sz > 0) && rd_ready;
    dropped = 1'b0;
    if (!reset) begin
      q.delete();
      m_ovf = 1'b0;
    end else begin
      if (p) void'(q.pop_front());
      if (data_ready) begin
        if (sz < DEPTH || p) q.push_back({frame_err, parity_err, rx_data});
        else dropped = 1'b1;
      end
      if (dropped) m_ovf = 1'b1;
      else if (overflow_clr) m_ovf = 1'b0;
    end
    @(negedge clk);
    compare();
  endtask

  task automatic idle_inputs();
    data_ready = 0; rd_ready = 0; overflow_clr = 0; parity_err = 0; frame_err = 0;
  endtask

  task automatic push(input logic [DATA_BITS-1:0] d, input bit pe, input bit fe);
    rx_data = d; parity_err = pe; frame_err = fe; data_ready = 1;
    tick();
    idle_inputs();
  endtask

  task automatic pop1();
    rd_ready = 1;
    tick();
    idle_inputs();
  endtask

  initial begin
    ntests = 0; nfail = 0; m_ovf = 0;
    // Reset and idle
    reset = 0; tick(); tick(); reset = 1; tick();
    chk("rst_level", 32'(level), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_valid", 32'(rd_valid), 0);
    chk("rst_ovf", 32'(overflow), 0);
    pop1();
    chk("idle_pop_level", 32'(level), 0);
    chk("idle_pop_empty", 32'(empty), 1);

    // Basic FWFT order with a continuous drain
    push(8'h41, 0, 0);
    chk("fwft_valid", 32'(rd_valid), 1);
    chk("fwft_data", 32'(rd_data), 32'h41);
    push(8'h42, 0, 0); push(8'h43, 0, 0);
    chk("lvl3", 32'(level), 3);
    rd_ready = 1;
    tick(); chk("drain_42", 32'(rd_data), 32'h42); chk("lvl2", 32'(level), 2);
    tick(); chk("drain_43", 32'(rd_data), 32'h43); chk("lvl1", 32'(level), 1);
    tick(); chk("lvl0", 32'(level), 0); chk("empty_after", 32'(empty), 1);
    idle_inputs();

    // Error flags travel with their own byte
    push(8'h55, 1, 0); push(8'hAA, 0, 1);
    chk("pe_data", 32'(rd_data), 32'h55);
    chk("pe_flag", 32'(rd_parity_err), 1);
    chk("pe_nofe", 32'(rd_frame_err), 0);
    pop1();
    chk("fe_data", 32'(rd_data), 32'hAA);
    chk("fe_nope", 32'(rd_parity_err), 0);
    chk("fe_flag", 32'(rd_frame_err), 1);
    pop1();

    // Fill, overflow, drain, clear
    for (int i = 0; i < DEPTH; i++) push(8'(i), 0, 0);
    chk("full_set", 32'(full), 1);
    push(8'hFF, 0, 0);
    chk("ovf_set", 32'(overflow), 1);
    chk("ovf_level", 32'(level), 16);
    for (int i = 0; i < DEPTH; i++) begin
      chk("ovf_drain", 32'(rd_data), 32'(i));
      pop1();
    end
    chk("ovf_empty", 32'(empty), 1);
    chk("ovf_sticky", 32'(overflow), 1);
    overflow_clr = 1; tick(); idle_inputs();
    chk("ovf_clr", 32'(overflow), 0);

    // Full with simultaneous push and pop
    for (int i = 0; i < DEPTH; i++) push(8'(8'h20 + i), 0, 0);
    rd_ready = 1; rx_data = 8'h99; data_ready = 1; tick(); idle_inputs();
    chk("pp_level", 32'(level), 16);
    chk("pp_ovf", 32'(overflow), 0);
    for (int i = 0; i < 15; i++) pop1();
    chk("pp_head", 32'(rd_data), 32'h99);
    pop1();

    // Interleaved pushes/pops that wrap the pointers several times
    for (int i = 0; i < 40; i++) begin
      rx_data = 8'($urandom); data_ready = 1; rd_ready = (i % 3) != 0;
      tick();
    end
    idle_inputs();
    while (!empty && ntests < 100000) pop1();

    // Random traffic including drops and clear/drop collisions
    for (int i = 0; i < 600; i++) begin
      data_ready   = ($urandom_range(0, 99) < 60);
      rx_data      = 8'($urandom);
      parity_err   = $urandom_range(0, 3) == 0;
      frame_err    = $urandom_range(0, 3) == 0;
      rd_ready     = (i < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
      overflow_clr = $urandom_range(0, 15) == 0;
      tick();
    end
    idle_inputs();

    // Reset mid-stream with a simultaneous strobe
    for (int i = 0; i < DEPTH + 1; i++) push(8'(8'h60 + i), 0, 0);
    for (int i = 0; i < 11; i++) pop1();
    chk("pre_rst_level", 32'(level), 5);
    reset = 0; data_ready = 1; rx_data = 8'h77; rd_ready = 1; overflow_clr = 0; tick();
    reset = 1; idle_inputs();
    chk("mid_rst_level", 32'(level), 0);
    chk("mid_rst_valid", 32'(rd_valid), 0);
    chk("mid_rst_ovf", 32'(overflow), 0);
    tick();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side buffer between the UART receiver and the consumer of received bytes (CPU bus bridge or loopback logic). It captures each byte the receiver reports with its `data_ready` pulse, together with that byte's parity and framing error flags, into a circular FIFO. It presents the oldest entry on a valid/ready read port and flags overflow when bytes arrive faster than they are drained.

## Interface
- `DATA_BITS`, 8: width of one received character; legal range 5–9.
- `DEPTH`, 16: number of FIFO entries; power of two, at least 2.
- `clk` input 1: single system clock; all logic is on its rising edge.
- `reset` input 1: synchronous, active-low reset; sampled on `clk` rising edge.
- `rx_data` input DATA_BITS: received character; valid only while `data_ready`=1.
- `data_ready` input 1: one-cycle write strobe from the receiver.
- `parity_err` input 1: parity error for the character on `rx_data`; qualified by `data_ready`.
- `frame_err` input 1: stop-bit error for the character on `rx_data`; qualified by `data_ready`.
- `rd_data` output DATA_BITS: character at the FIFO head.
- `rd_parity_err` output 1: parity flag stored with the head entry.
- `rd_frame_err` output 1: frame flag stored with the head entry.
- `rd_valid` output 1: the head entry is valid (FIFO not empty).
- `rd_ready` input 1: consumer accepts the head entry. A pop occurs when `rd_valid & rd_ready`.
- `level` output $clog2(DEPTH)+1: current entry count, 0..DEPTH.
- `full` output 1: `level == DEPTH`.
- `empty` output 1: `level == 0`.
- `overflow` output 1: sticky flag; at least one character was dropped.
- `overflow_clr` input 1: one-cycle pulse that clears `overflow`.

## Operation
- Storage: DEPTH entries of `DATA_BITS+2` bits, holding {frame_err, parity_err, data}. Write pointer, read pointer and count are registered.
- Pointers are $clog2(DEPTH) bits and wrap from DEPTH-1 to 0 by natural overflow. `full` and `empty` are derived from the count, not from pointer equality.
- Push condition: `data_ready & (~full | pop)`.
  - A push writes the entry at the write pointer and increments the pointer.
  - Error flags are stored even when set. The byte is never discarded for a parity or framing error.
- Pop condition: `rd_valid & rd_ready`. A pop increments the read pointer.
- Count update:
  - push only: +1.
  - pop only: −1.
  - both, or neither: unchanged.
- Full and simultaneous push/pop: the push is accepted, count stays DEPTH, and `overflow` is not set.
- Overflow: when `data_ready` arrives while `full` and there is no pop:
  - the character is dropped;
  - the write pointer and count are unchanged;
  - `overflow` is set to 1.
- `overflow_clr`:
  - clears `overflow` on the next edge;
  - if a drop occurs in the same cycle, the set wins and `overflow` stays 1.
- Empty and `data_ready`: the push is accepted. A pop is impossible that cycle because `rd_valid`=0.
- `rd_ready` while `rd_valid`=0 has no effect.
- Read port is first-word fall-through:
  - `rd_data`, `rd_parity_err` and `rd_frame_err` come combinationally from the storage entry at the read pointer.
  - Their value is don't-care while `rd_valid`=0.

## Timing
- Reset (`reset`=0 at an edge):
  - pointers and count go to 0, so `level`=0, `empty`=1, `full`=0, `rd_valid`=0;
  - `overflow`=0;
  - storage contents are not reset.
- Reset takes priority over push, pop and `overflow_clr` in the same cycle.
- Reset asserted mid-stream discards every buffered entry.
- Write-to-read latency: `data_ready` sampled at edge N gives `rd_valid`=1 and the entry on `rd_data` during the cycle after edge N.
- Pop latency: a pop sampled at edge N presents the next entry, or deasserts `rd_valid`, after edge N.
- `level`, `full`, `empty` and `overflow` are updated by the same edge as the push or pop that changes them.
- The consumer may hold `rd_ready`=1 continuously and drains one entry per clock.
- The block accepts `data_ready` on back-to-back cycles; the receiver normally pulses it once per character.

## Test plan
- Reset then idle, DEPTH=16:
  - `level`=0, `empty`=1, `full`=0, `rd_valid`=0, `overflow`=0.
  - Pulsing `rd_ready` leaves all outputs unchanged.
- Push 0x41, 0x42, 0x43 with flags clear, then hold `rd_ready`=1:
  - `rd_valid` rises one cycle after the first strobe;
  - `rd_data` reads 0x41, 0x42, 0x43 on consecutive cycles;
  - `level` steps 3→2→1→0, then `empty`=1.
- Push 0x55 with `parity_err`=1, then 0xAA with `frame_err`=1:
  - entries read back with the matching `rd_parity_err` / `rd_frame_err`;
  - the flags do not leak to the adjacent entry.
- Push 16 bytes 0x00..0x0F (`full`=1), then push 0xFF:
  - `overflow`=1 and `level` stays 16;
  - draining yields exactly 0x00..0x0F.
  - Then `overflow_clr` gives `overflow`=0.
- While full, assert `data_ready` (0x99) and a pop in the same cycle:
  - `level` stays 16 and `overflow` stays 0;
  - after 15 further pops, 0x99 is at the head.
- Wrap and reset:
  - run 40 pushes interleaved with pops so the pointers wrap at least twice; the data order is preserved;
  - assert `reset`=0 with `level`=5 and `data_ready`=1 in the same cycle; the next cycle shows `level`=0, `rd_valid`=0, `overflow`=0.
